// File: rtl/box_collider.sv
// Player/obstacle bounding-box collider. Samples the raw overlap on each animation
// tick, confirms it over several ticks, then counts hits with a cooldown window
// between them. Raises a sticky game_over once enough hits have been accepted.
module box_collider #(
  parameter int unsigned W        = 12,
  parameter int unsigned CONFIRM  = 2,
  parameter int unsigned COOLDOWN = 60,
  parameter int unsigned MAX_HITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         animate,
  input  logic [W-1:0] ax1,
  input  logic [W-1:0] ax2,
  input  logic [W-1:0] ay1,
  input  logic [W-1:0] ay2,
  input  logic [W-1:0] bx1,
  input  logic [W-1:0] bx2,
  input  logic [W-1:0] by1,
  input  logic [W-1:0] by2,
  output logic         overlap,
  output logic         hit,
  output logic [3:0]   hits,
  output logic         invuln,
  output logic         game_over
);

  localparam int unsigned CntW = $clog2(CONFIRM + 1);
  localparam int unsigned CdW  = $clog2(COOLDOWN + 1);

  localparam logic [CntW-1:0] ConfirmVal  = CntW'(CONFIRM);
  localparam logic [CdW-1:0]  CooldownVal = CdW'(COOLDOWN);
  localparam logic [3:0]      MaxHitsVal  = 4'(MAX_HITS);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StArmed    = 3'd1;
  localparam logic [2:0] StConfirm  = 3'd2;
  localparam logic [2:0] StCooldown = 3'd3;
  localparam logic [2:0] StOver     = 3'd4;

  logic            a_valid;
  logic            b_valid;
  logic            overlap_c;
  logic            overlap_q;
  logic            tick_q;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CdW-1:0]  cd_q, cd_d;
  logic            hit_q, hit_d;
  logic [3:0]      hits_q, hits_d;
  logic            invuln_q, invuln_d;
  logic            game_over_q, game_over_d;
  logic            accept;
  logic            drop;

  // Raw inclusive-edge overlap; inverted (wrapped) boxes count as empty.
  always_comb begin
    a_valid   = (ax1 <= ax2) && (ay1 <= ay2);
    b_valid   = (bx1 <= bx2) && (by1 <= by2);
    overlap_c = a_valid && b_valid &&
                (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);
  end

  // Stage 1: capture overlap on the frame strobe and flag a tick for the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      overlap_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= animate;
      if (animate) overlap_q <= overlap_c;
    end
  end

  // Stage 2: confirm/cooldown FSM next-state and hit bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cd_d        = cd_q;
    hit_d       = 1'b0;
    hits_d      = hits_q;
    invuln_d    = invuln_q;
    game_over_d = game_over_q;
    accept      = 1'b0;
    drop        = 1'b0;

    case (state_q)
      StIdle: begin
        if (enable) state_d = StArmed;
      end
      StArmed: begin
        if (!enable) begin
          drop = 1'b1;
        end else if (tick_q && overlap_q) begin
          if (ConfirmVal == CntW'(1)) begin
            accept = 1'b1;
          end else begin
            cnt_d   = CntW'(1);
            state_d = StConfirm;
          end
        end
      end
      StConfirm: begin
        if (!enable) begin
          drop = 1'b1;
        end else if (tick_q) begin
          if (overlap_q) begin
            if (cnt_q + CntW'(1) == ConfirmVal) accept = 1'b1;
            else                                cnt_d  = cnt_q + CntW'(1);
          end else begin
            cnt_d   = '0;
            state_d = StArmed;
          end
        end
      end
      StCooldown: begin
        if (!enable) begin
          drop = 1'b1;
        end else if (tick_q) begin
          cd_d = cd_q - CdW'(1);
          if (cd_q == CdW'(1)) begin
            state_d  = StArmed;
            invuln_d = 1'b0;
            cnt_d    = '0;
          end
        end
      end
      StOver: begin
        // Absorbing until reset.
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Enable drop wins over a simultaneous tick; hit count survives.
    if (drop) begin
      state_d  = StIdle;
      cnt_d    = '0;
      cd_d     = '0;
      invuln_d = 1'b0;
    end

    if (accept) begin
      hit_d  = 1'b1;
      hits_d = hits_q + 4'd1;
      cnt_d  = '0;
      if (hits_q + 4'd1 == MaxHitsVal) begin
        state_d     = StOver;
        game_over_d = 1'b1;
        invuln_d    = 1'b0;
      end else begin
        cd_d     = CooldownVal;
        state_d  = StCooldown;
        invuln_d = 1'b1;
      end
    end
  end

  // Stage 2 state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cd_q        <= '0;
      hit_q       <= 1'b0;
      hits_q      <= 4'd0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cd_q        <= cd_d;
      hit_q       <= hit_d;
      hits_q      <= hits_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign overlap   = overlap_q;
  assign hit       = hit_q;
  assign hits      = hits_q;
  assign invuln    = invuln_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_box_collider.sv
// Directed bench for box_collider with default parameters (CONFIRM=2,
// COOLDOWN=60, MAX_HITS=3). Inputs change on the falling edge, outputs are
// sampled on the falling edge; each frame tick spans four clock cycles.
module tb_box_collider;

  localparam int unsigned W = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         animate;
  logic [W-1:0] ax1, ax2, ay1, ay2;
  logic [W-1:0] bx1, bx2, by1, by2;
  logic         overlap;
  logic         hit;
  logic [3:0]   hits;
  logic         invuln;
  logic         game_over;

  int n_checks = 0;
  int n_errors = 0;
  int hit_pulses = 0;

  box_collider #(
    .W(W), .CONFIRM(2), .COOLDOWN(60), .MAX_HITS(3)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .animate(animate),
    .ax1(ax1), .ax2(ax2), .ay1(ay1), .ay2(ay2),
    .bx1(bx1), .bx2(bx2), .by1(by1), .by2(by2),
    .overlap(overlap), .hit(hit), .hits(hits), .invuln(invuln),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  // hit is a single-cycle pulse, so one falling-edge sample per pulse.
  always @(negedge clk) if (hit === 1'b1) hit_pulses++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_boxes(input int a1, input int a2, input int a3, input int a4,
                           input int b1, input int b2, input int b3, input int b4);
    ax1 = W'(a1); ax2 = W'(a2); ay1 = W'(a3); ay2 = W'(a4);
    bx1 = W'(b1); bx2 = W'(b2); by1 = W'(b3); by2 = W'(b4);
  endtask

  // Called at a falling edge; reports hit in the cycle two after the strobe.
  task automatic do_tick(output logic hit_seen);
    animate = 1'b1;
    @(negedge clk);
    animate = 1'b0;
    @(negedge clk);
    hit_seen = hit;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic h;
    int   base;
    int   hit_ticks[$];

    reset = 1'b1; enable = 1'b1; animate = 1'b0;
    set_boxes(100, 110, 200, 210, 105, 115, 205, 215);
    repeat (3) @(negedge clk);
    check_val("rst_overlap", overlap, 0);
    check_val("rst_hit", hit, 0);
    check_val("rst_hits", hits, 0);
    check_val("rst_invuln", invuln, 0);
    check_val("rst_game_over", game_over, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic confirm, latency and cooldown length.
    base = hit_pulses;
    do_tick(h);
    check_val("a_tick1_overlap", overlap, 1);
    check_val("a_tick1_no_hit", h, 0);
    do_tick(h);
    check_val("a_tick2_hit_latency", h, 1);
    check_val("a_one_pulse", hit_pulses - base, 1);
    check_val("a_hits", hits, 1);
    check_val("a_invuln_on", invuln, 1);
    for (int i = 0; i < 59; i++) do_tick(h);
    check_val("a_invuln_59", invuln, 1);
    check_val("a_no_hit_in_cd", hit_pulses - base, 1);
    do_tick(h);
    check_val("a_invuln_off_60", invuln, 0);
    do_tick(h);
    check_val("a_fresh_confirm1", h, 0);
    do_tick(h);
    check_val("a_fresh_confirm2", h, 1);
    check_val("a_hits2", hits, 2);

    // Touching edges overlap; one pixel apart does not.
    do_reset();
    set_boxes(100, 110, 200, 210, 110, 120, 205, 215);
    do_tick(h);
    check_val("touch_overlap", overlap, 1);
    do_reset();
    base = hit_pulses;
    set_boxes(100, 110, 200, 210, 111, 120, 205, 215);
    do_tick(h);
    check_val("gap_overlap", overlap, 0);
    do_tick(h);
    do_tick(h);
    check_val("gap_no_hit", hit_pulses - base, 0);
    check_val("gap_hits", hits, 0);

    // Alternating overlap never confirms.
    do_reset();
    base = hit_pulses;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) set_boxes(100, 110, 200, 210, 105, 115, 205, 215);
      else            set_boxes(100, 110, 200, 210, 300, 310, 205, 215);
      do_tick(h);
      check_val("alt_overlap", overlap, (i % 2 == 0) ? 1 : 0);
    end
    check_val("alt_no_hit", hit_pulses - base, 0);
    check_val("alt_hits", hits, 0);

    // Wrapped obstacle box is empty.
    do_reset();
    base = hit_pulses;
    set_boxes(100, 110, 200, 210, 4090, 5, 205, 215);
    do_tick(h);
    check_val("wrap_overlap", overlap, 0);
    do_tick(h);
    do_tick(h);
    check_val("wrap_no_hit", hit_pulses - base, 0);

    // Continuous overlap to game over.
    do_reset();
    check_val("over_rst_hits", hits, 0);
    set_boxes(100, 110, 200, 210, 105, 115, 205, 215);
    base = hit_pulses;
    for (int i = 1; i <= 250; i++) begin
      do_tick(h);
      if (h) hit_ticks.push_back(i);
      if (i == 125) check_val("over_go_before", game_over, 0);
      if (i == 126) check_val("over_go_after", game_over, 1);
    end
    check_val("over_hit_count", hit_ticks.size(), 3);
    if (hit_ticks.size() == 3) begin
      check_val("over_hit1_tick", hit_ticks[0], 2);
      check_val("over_hit2_tick", hit_ticks[1], 64);
      check_val("over_hit3_tick", hit_ticks[2], 126);
    end
    check_val("over_pulses", hit_pulses - base, 3);
    check_val("over_hits", hits, 3);
    check_val("over_game_over", game_over, 1);
    check_val("over_invuln", invuln, 0);
    do_reset();
    check_val("over_rst_go", game_over, 0);
    check_val("over_rst_hits2", hits, 0);

    // Enable drop during cooldown.
    do_reset();
    do_tick(h);
    do_tick(h);
    check_val("en_hit", h, 1);
    for (int i = 0; i < 5; i++) do_tick(h);
    check_val("en_invuln_pre", invuln, 1);
    enable = 1'b0;
    @(negedge clk);
    check_val("en_invuln_drop", invuln, 0);
    check_val("en_hits_kept", hits, 1);
    enable = 1'b1;
    @(negedge clk);
    do_tick(h);
    check_val("en_refresh1", h, 0);
    do_tick(h);
    check_val("en_refresh2", h, 1);
    check_val("en_hits2", hits, 2);

    // Reset during confirm.
    do_reset();
    do_tick(h);
    check_val("rc_pre_overlap", overlap, 1);
    reset = 1'b1;
    @(negedge clk);
    check_val("rc_overlap", overlap, 0);
    check_val("rc_hit", hit, 0);
    check_val("rc_hits", hits, 0);
    check_val("rc_invuln", invuln, 0);
    check_val("rc_game_over", game_over, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    do_tick(h);
    check_val("rc_fresh1", h, 0);
    do_tick(h);
    check_val("rc_fresh2", h, 1);
    check_val("rc_hits1", hits, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
